discrete_sound_trigger: RTL and testbench

//  CPU-side transmitter of discrete sound trigger enables (e.g. walk_en) into the discrete circuit models.

---
 rtl/discrete_pkg.sv | 17 +
 rtl/discrete_trigger_stretch.sv | 96 +++++++++
 rtl/discrete_sound_trigger.sv | 69 ++++++
 tb/tb_discrete_sound_trigger.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// rtl/discrete_pkg.sv - shared types and helpers for the discrete sound trigger block
// Purpose: channel state encoding and a ms-to-sample-count conversion for hold times.
// Ports: none (package).
package discrete_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } trig_state_t;

  // Converts a duration in milliseconds into a count of audio samples.
  function automatic int ms_to_samples(input int ms, input int sample_rate);
    return (ms * sample_rate) / 1000;
  endfunction

endpackage

// File: rtl/discrete_trigger_stretch.sv
// rtl/discrete_trigger_stretch.sv - one trigger channel: rise capture, hold FSM and sample-aligned enable
// Purpose: stretches a latch bit to at least MIN_HOLD_SAMPLES audio ticks and re-times it to audio_clk_en.
// Configuration: DISCRETE_TRIGGER_RETRIGGER_EN makes a new rising edge during HOLD reload the hold counter;
//   without it a rising edge during HOLD is discarded (one-shot, non-retriggerable).
// Ports:
//   clk          in  system clock
//   I_RSTn       in  asynchronous active-low reset
//   audio_clk_en in  one-clk strobe per audio sample
//   latch_i      in  raw latch bit for this channel
//   trig_en_o    out stretched trigger enable, changes only on audio_clk_en
//   hold_busy_o  out hold counter non-zero, changes only on audio_clk_en
module discrete_trigger_stretch
  import discrete_pkg::*;
#(
  parameter int MIN_HOLD_SAMPLES = 480,
  localparam int CNT_W = $clog2(MIN_HOLD_SAMPLES + 1)
) (
  input  logic clk,
  input  logic I_RSTn,
  input  logic audio_clk_en,
  input  logic latch_i,
  output logic trig_en_o,
  output logic hold_busy_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_HOLD_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  trig_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             latch_prev_q;
  logic             rise;
  logic             pend_eff;

  // A rise in the same cycle as a tick is seen directly through pend_eff,
  // so a one-clk latch pulse is never lost.
  assign rise     = latch_i & ~latch_prev_q;
  assign pend_eff = pend_q | rise;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      latch_prev_q <= latch_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = audio_clk_en ? 1'b0 : pend_eff;
    if (audio_clk_en) begin
      case (state_q)
        IDLE: begin
          if (pend_eff || latch_i) begin
            state_d = ACTIVE;
            cnt_d   = RELOAD;
          end
        end
        ACTIVE: begin
          cnt_d = (cnt_q != '0) ? cnt_q - ONE : '0;
          if (!latch_i) begin
            state_d = (cnt_q == '0) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = latch_i ? ACTIVE : IDLE;
          end else begin
`ifdef DISCRETE_TRIGGER_RETRIGGER_EN
            cnt_d = pend_eff ? RELOAD : cnt_q - ONE;
`else
            cnt_d = cnt_q - ONE;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Both decode straight from registers that only move on audio_clk_en.
  assign trig_en_o   = (state_q != IDLE);
  assign hold_busy_o = (cnt_q != '0);

endmodule

// File: rtl/discrete_sound_trigger.sv
// rtl/discrete_sound_trigger.sv - 74LS259-style addressable sound latch feeding per-channel trigger stretchers
// Purpose: CPU writes set/clear one addressed latch bit; each bit drives a stretcher channel.
// Configuration: DISCRETE_TRIGGER_RETRIGGER_EN (see discrete_trigger_stretch).
// Ports:
//   clk, I_RSTn   clock and asynchronous active-low reset
//   audio_clk_en  one-clk strobe per audio sample
//   cpu_wr        latch write strobe
//   cpu_addr      bit select
//   cpu_data      value written to the selected bit
//   clear_n       synchronous active-low clear of all latch bits
//   latch_q       raw latch contents
//   trig_en       stretched, sample-aligned trigger enables
//   hold_busy     per-channel hold counter non-zero
module discrete_sound_trigger
  import discrete_pkg::*;
#(
  parameter int SAMPLE_RATE      = 48000,
  parameter int NUM_TRIGGERS     = 8,
  parameter int MIN_HOLD_SAMPLES = ms_to_samples(10, SAMPLE_RATE),
  localparam int ADDR_W = $clog2(NUM_TRIGGERS)
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    audio_clk_en,
  input  logic                    cpu_wr,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    cpu_data,
  input  logic                    clear_n,
  output logic [NUM_TRIGGERS-1:0] latch_q,
  output logic [NUM_TRIGGERS-1:0] trig_en,
  output logic [NUM_TRIGGERS-1:0] hold_busy
);

  logic [NUM_TRIGGERS-1:0] latch_bits_q, latch_bits_d;

  // Clear mode takes priority over a write in the same cycle.
  always_comb begin
    latch_bits_d = latch_bits_q;
    if (!clear_n) begin
      latch_bits_d = '0;
    end else if (cpu_wr) begin
      latch_bits_d[cpu_addr] = cpu_data;
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      latch_bits_q <= '0;
    end else begin
      latch_bits_q <= latch_bits_d;
    end
  end

  assign latch_q = latch_bits_q;

  for (genvar i = 0; i < NUM_TRIGGERS; i++) begin : g_chan
    discrete_trigger_stretch #(
      .MIN_HOLD_SAMPLES(MIN_HOLD_SAMPLES)
    ) u_stretch (
      .clk         (clk),
      .I_RSTn      (I_RSTn),
      .audio_clk_en(audio_clk_en),
      .latch_i     (latch_bits_q[i]),
      .trig_en_o   (trig_en[i]),
      .hold_busy_o (hold_busy[i])
    );
  end

endmodule

// File: tb/tb_discrete_sound_trigger.sv
// tb/tb_discrete_sound_trigger.sv - self-checking bench for discrete_sound_trigger
module tb_discrete_sound_trigger;

  localparam int MIN_HOLD = 480;
`ifdef DISCRETE_TRIGGER_RETRIGGER_EN
  localparam int RETRIG_TOTAL = 780;
`else
  localparam int RETRIG_TOTAL = 480;
`endif

  logic       clk = 1'b0;
  logic       I_RSTn = 1'b0;
  logic       audio_clk_en = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [2:0] cpu_addr = '0;
  logic       cpu_data = 1'b0;
  logic       clear_n = 1'b1;
  logic [7:0] latch_q, trig_en, hold_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic       data;
    logic       clr_n;
    logic [7:0] exp_latch;
  } vec_t;

  discrete_sound_trigger dut (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .clear_n     (clear_n),
    .latch_q     (latch_q),
    .trig_en     (trig_en),
    .hold_busy   (hold_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %0h expected an entry", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  task automatic do_reset();
    #2 I_RSTn = 1'b0;
    #3 I_RSTn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One audio tick followed by one quiet cycle; outputs are sampled 1 ns after the tick edge.
  task automatic tick();
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1 audio_clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
    @(posedge clk);
    #1 cpu_wr = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] a);
    wr(a, 1'b1);
    wr(a, 1'b0);
  endtask

  vec_t vecs[9];
  int   on_cnt, other_cnt;

  initial begin
    vecs[0] = '{1'b1, 3'd3, 1'b1, 1'b1, 8'h08};
    vecs[1] = '{1'b1, 3'd0, 1'b1, 1'b1, 8'h09};
    vecs[2] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'h89};
    vecs[3] = '{1'b0, 3'd1, 1'b1, 1'b1, 8'h89};
    vecs[4] = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h81};
    vecs[5] = '{1'b1, 3'd5, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 3'd5, 1'b1, 1'b1, 8'h20};
    vecs[7] = '{1'b1, 3'd5, 1'b1, 1'b1, 8'h20};
    vecs[8] = '{1'b1, 3'd2, 1'b0, 1'b1, 8'h20};

    #12 I_RSTn = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_latch_q", 32'(latch_q), 32'h0);
    chk("reset_trig_en", 32'(trig_en), 32'h0);
    chk("reset_hold_busy", 32'(hold_busy), 32'h0);

    // Latch behaviour, no audio ticks: trig_en must not move.
    for (int i = 0; i < 9; i++) begin
      cpu_wr = vecs[i].wr; cpu_addr = vecs[i].addr;
      cpu_data = vecs[i].data; clear_n = vecs[i].clr_n;
      push_exp($sformatf("vec%0d_latch_q", i), 32'(vecs[i].exp_latch));
      push_exp($sformatf("vec%0d_trig_en", i), 32'h0);
      @(posedge clk);
      #1;
      cpu_wr = 1'b0; clear_n = 1'b1;
      pop_chk(32'(latch_q));
      pop_chk(32'(trig_en));
    end

    // 1-clk pulse on bit 3 between ticks: exactly MIN_HOLD ticks on.
    do_reset();
    pulse(3'd3);
    push_exp("pulse3_first_tick", 32'h08);
    push_exp("pulse3_on_ticks", 32'(MIN_HOLD));
    push_exp("pulse3_other_on", 32'h0);
    push_exp("pulse3_end_trig", 32'h0);
    push_exp("pulse3_end_busy", 32'h0);
    on_cnt = 0; other_cnt = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (t == 0) pop_chk(32'(trig_en));
      if (trig_en[3]) on_cnt++;
      if ((trig_en & 8'hF7) != 8'h0) other_cnt++;
    end
    pop_chk(32'(on_cnt));
    pop_chk(32'(other_cnt));
    pop_chk(32'(trig_en));
    pop_chk(32'(hold_busy));

    // Hold bit 5 for 2000 ticks, then clear.
    do_reset();
    wr(3'd5, 1'b1);
    push_exp("hold5_busy_first", 32'h20);
    push_exp("hold5_busy_after_480", 32'h0);
    push_exp("hold5_on_ticks", 32'd2000);
    push_exp("hold5_off_after_clear", 32'h0);
    on_cnt = 0;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (t == 0) pop_chk(32'(hold_busy));
      if (t == 479) pop_chk(32'(hold_busy));
      if (trig_en[5]) on_cnt++;
    end
    pop_chk(32'(on_cnt));
    clear_n = 1'b0;
    @(posedge clk);
    #1 clear_n = 1'b1;
    tick();
    pop_chk(32'(trig_en));

    // Write and clear in the same cycle: clear wins, no pend.
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 3'd1; cpu_data = 1'b1; clear_n = 1'b0;
    push_exp("wr_clr_latch_q", 32'h0);
    push_exp("wr_clr_trig_en", 32'h0);
    @(posedge clk);
    #1 cpu_wr = 1'b0; clear_n = 1'b1;
    pop_chk(32'(latch_q));
    repeat (3) tick();
    pop_chk(32'(trig_en));

    // Rising edge on bit 0 during hold, at tick 300.
    do_reset();
    pulse(3'd0);
    push_exp("retrig0_on_ticks", 32'(RETRIG_TOTAL));
    on_cnt = 0;
    for (int t = 0; t < 900; t++) begin
      if (t == 300) pulse(3'd0);
      tick();
      if (trig_en[0]) on_cnt++;
    end
    pop_chk(32'(on_cnt));

    // Write coincident with a tick lands on the following tick.
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_data = 1'b1; audio_clk_en = 1'b1;
    push_exp("coinc_latch_q", 32'h04);
    push_exp("coinc_trig_same_tick", 32'h0);
    push_exp("coinc_trig_next_tick", 32'h04);
    @(posedge clk);
    #1 cpu_wr = 1'b0; audio_clk_en = 1'b0;
    pop_chk(32'(latch_q));
    pop_chk(32'(trig_en));
    @(posedge clk);
    #1;
    tick();
    pop_chk(32'(trig_en));

    // Asynchronous reset in the middle of a hold.
    do_reset();
    pulse(3'd6);
    repeat (100) tick();
    chk("rst_mid_before", 32'(trig_en), 32'h40);
    @(negedge clk);
    #2 I_RSTn = 1'b0;
    #1;
    chk("rst_mid_trig_async", 32'(trig_en), 32'h0);
    chk("rst_mid_busy_async", 32'(hold_busy), 32'h0);
    chk("rst_mid_latch_async", 32'(latch_q), 32'h0);
    #4 I_RSTn = 1'b1;
    @(posedge clk);
    #1;
    on_cnt = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (trig_en != 8'h0) on_cnt++;
    end
    chk("rst_mid_no_residual", 32'(on_cnt), 32'h0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
